// File: rtl/bit_fill_if.sv
// rtl/bit_fill_if.sv - go/done request and result bundle for bit_fill
interface bit_fill_if #(
    parameter int WIDTH = 8
) ();
    logic                         go;
    logic [$clog2(WIDTH+1)-1:0]   in;
    logic [WIDTH-1:0]             out;
    logic                         done;

    modport master (output go, output in, input out, input done);
    modport slave  (input go, input in, output out, output done);
endinterface

// File: rtl/bit_fill.sv
// rtl/bit_fill.sv - sequential k-ones word generator, one bit shifted in per cycle
module bit_fill #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    bit_fill_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {START, COMPUTE, DONE} state_t;

    state_t              state;
    logic [CW-1:0]       count_r;
    logic [WIDTH-1:0]    n_r;
    logic [WIDTH-1:0]    out_r;
    logic                done_r;
    logic [CW-1:0]       load_count;
    logic [WIDTH-1:0]    n_shift;

    // Requests wider than the word saturate to an all-ones result.
    assign load_count = (bus.in > CW'(WIDTH)) ? CW'(WIDTH) : bus.in;
    assign n_shift    = (n_r << 1) | WIDTH'(1);

    assign bus.out  = out_r;
    assign bus.done = done_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= START;
            count_r <= '0;
            n_r     <= '0;
            out_r   <= '0;
            done_r  <= 1'b0;
        end else begin
            case (state)
                START: begin
                    done_r <= 1'b0;
                    if (bus.go) begin
                        count_r <= load_count;
                        n_r     <= '0;
                        state   <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (count_r != '0) begin
                        n_r     <= n_shift;
                        count_r <= count_r - 1'b1;
                    end else begin
                        // out only moves here, so it holds the last result through a new COMPUTE
                        out_r  <= n_r;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.go) begin
                        count_r <= load_count;
                        n_r     <= '0;
                        done_r  <= 1'b0;
                        state   <= COMPUTE;
                    end
                end
                default: begin
                    state  <= START;
                    done_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bit_fill.sv
// tb/tb_bit_fill.sv - self-checking bench for bit_fill at WIDTH 8, 5 and 1
module tb_bit_fill;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bit_fill_if #(.WIDTH(8)) bf8 ();
    bit_fill_if #(.WIDTH(5)) bf5 ();
    bit_fill_if #(.WIDTH(1)) bf1 ();

    bit_fill #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bf8));
    bit_fill #(.WIDTH(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bf5));
    bit_fill #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bf1));

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int         sel;
        int         k;
        logic [7:0] exp_out;
        int         exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic g, input int k);
        case (sel)
            0: begin bf8.go = g; bf8.in = 4'(k); end
            1: begin bf5.go = g; bf5.in = 3'(k); end
            default: begin bf1.go = g; bf1.in = 1'(k); end
        endcase
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            0: return bf8.done;
            1: return bf5.done;
            default: return bf1.done;
        endcase
    endfunction

    function automatic logic [7:0] get_out(input int sel);
        case (sel)
            0: return bf8.out;
            1: return 8'(bf5.out);
            default: return 8'(bf1.out);
        endcase
    endfunction

    // Reference: k clamped to the word width, result is 2^k - 1, ready k+2 edges after accept.
    function automatic int clamp(input int k, input int w);
        return (k > w) ? w : k;
    endfunction

    function automatic logic [31:0] model_word(input int k, input int w);
        return (32'd1 << clamp(k, w)) - 32'd1;
    endfunction

    // Pulse go for one edge, scramble in afterwards, then count edges until done.
    task automatic do_op(input int sel, input int k, output logic [7:0] got, output int lat);
        @(negedge clk);
        drive(sel, 1'b1, k);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        drive(sel, 1'b0, k ^ 5);
        while (!get_done(sel) && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        got = get_out(sel);
    endtask

    vec_t        vecs[$];
    logic [7:0]  got;
    int          lat;
    int          widths[3] = '{8, 5, 1};
    logic [7:0]  last8;
    int          pulses;

    initial begin
        bf8.go = 1'b0; bf8.in = '0;
        bf5.go = 1'b0; bf5.in = '0;
        bf1.go = 1'b0; bf1.in = '0;

        #1;
        check("reset_out", 32'(bf8.out), 32'h0);
        check("reset_done", 32'(bf8.done), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op(0, 5, got, lat);
        check("pre_reset_out", 32'(got), 32'h1F);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_out", 32'(bf8.out), 32'h0);
        check("async_reset_done", 32'(bf8.done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_done_low", 32'(bf8.done), 32'h0);

        vecs.push_back('{0, 0,  8'h00, 2});
        vecs.push_back('{0, 3,  8'h07, 5});
        vecs.push_back('{0, 8,  8'hFF, 10});
        vecs.push_back('{0, 1,  8'h01, 3});
        vecs.push_back('{0, 7,  8'h7F, 9});
        vecs.push_back('{0, 15, 8'hFF, 10});
        vecs.push_back('{1, 7,  8'h1F, 7});
        vecs.push_back('{1, 2,  8'h03, 4});
        vecs.push_back('{1, 5,  8'h1F, 7});
        vecs.push_back('{2, 1,  8'h01, 3});
        vecs.push_back('{2, 0,  8'h00, 2});
        foreach (vecs[i]) begin
            do_op(vecs[i].sel, vecs[i].k, got, lat);
            check($sformatf("tbl%0d_out", i), 32'(got), 32'(vecs[i].exp_out));
            check($sformatf("tbl%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            repeat (2) @(negedge clk);
            check($sformatf("tbl%0d_hold_done", i), 32'(get_done(vecs[i].sel)), 32'h1);
            check($sformatf("tbl%0d_hold_out", i), 32'(get_out(vecs[i].sel)), 32'(vecs[i].exp_out));
        end

        for (int it = 0; it < 1000; it++) begin
            int sel;
            int k;
            sel = (it % 10 == 9) ? int'($urandom_range(1, 2)) : 0;
            k = int'($urandom_range(0, (sel == 0) ? 8 : (sel == 1) ? 7 : 1));
            do_op(sel, k, got, lat);
            check("rand_out", 32'(got), model_word(k, widths[sel]));
            check("rand_lat", 32'(lat), 32'(clamp(k, widths[sel]) + 2));
            if (sel == 0) begin
                check("roundtrip_pop", 32'($countones(got)), 32'(k));
                last8 = 8'(model_word(k, 8));
            end
        end

        // go held high: k=2 then k=5, with in changed while the first op computes.
        pulses = 0;
        @(negedge clk);
        bf8.go = 1'b1;
        bf8.in = 4'd2;
        for (int n = 1; n <= 12; n++) begin
            logic [7:0] exp_o;
            @(posedge clk);
            @(negedge clk);
            if (n == 1) bf8.in = 4'd5;
            if (bf8.done) pulses++;
            exp_o = (n < 4) ? last8 : (n < 11) ? 8'h03 : 8'h1F;
            check($sformatf("b2b_done_%0d", n), 32'(bf8.done), 32'((n == 4) || (n == 11)));
            check($sformatf("b2b_out_%0d", n), 32'(bf8.out), 32'(exp_o));
        end
        check("b2b_pulses", 32'(pulses), 32'd2);
        bf8.go = 1'b0;
        lat = 0;
        while (!bf8.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_tail_out", 32'(bf8.out), 32'h1F);

        // Reset in the middle of COMPUTE aborts, then a fresh request completes.
        @(negedge clk);
        bf8.go = 1'b1;
        bf8.in = 4'd6;
        @(posedge clk);
        @(negedge clk);
        bf8.go = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out", 32'(bf8.out), 32'h0);
        check("abort_done", 32'(bf8.done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_stays_idle", 32'(bf8.done), 32'h0);
        check("abort_out_held0", 32'(bf8.out), 32'h0);
        do_op(0, 4, got, lat);
        check("after_abort_out", 32'(got), 32'h0F);
        check("after_abort_lat", 32'(lat), 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
